axi_fifoin_burst_writer: RTL and testbench

Parametrised AXI4 write master that drains a first-word-fall-through FIFO into memory as a programmed number of fixed-length INCR bursts. It is the next generation of the AXI_FIFOIN M00_AXI master, adding configurable data width and burst length, a run-time base address and burst count, FIFO back-pressure, and a sticky write-response error. It sits between the acquisition FIFO and the PS DDR port of the HP interconnect. It keeps the INIT_AXI_TXN / TXN_DONE / ERROR control handshake.

---
 rtl/axi_fifoin_burst_writer.sv | 173 +++++++++++++++++
 tb/tb_axi_fifoin_burst_writer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fifoin_burst_writer.sv
// AXI4 write master that drains a first-word-fall-through FIFO into memory as a run-time
// number of fixed-length INCR bursts, one burst outstanding at a time, with a sticky ERROR.
module axi_fifoin_burst_writer #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_BURST_LEN  = 16,
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_NUM_BURSTS_WIDTH = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     BASE_ADDR,
    input  logic [C_NUM_BURSTS_WIDTH-1:0]     NUM_BURSTS,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     FIFO_DOUT,
    input  logic                              FIFO_EMPTY,
    output logic                              FIFO_RD_EN,
    output logic                              BUSY,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int unsigned BytesPerBeat = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned BurstBytes   = C_M_AXI_BURST_LEN * BytesPerBeat;
    localparam int unsigned AlignBits    = $clog2(BurstBytes);
    localparam int unsigned BeatW        = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;

    localparam logic [BeatW-1:0]              LastBeat  = BeatW'(C_M_AXI_BURST_LEN - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrStep  = C_M_AXI_ADDR_WIDTH'(BurstBytes);
    // Burst-size alignment keeps every burst inside one 4 KB page.
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AlignMask = {C_M_AXI_ADDR_WIDTH{1'b1}} << AlignBits;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StDone} state_e;

    state_e                          state_q;
    logic                            init_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic                            awvalid_q;
    logic                            bready_q;
    logic                            busy_q;
    logic                            txn_done_q;
    logic                            error_q;
    logic [BeatW-1:0]                beat_q;
    logic [C_NUM_BURSTS_WIDTH-1:0]   remaining_q;

    logic init_pulse;
    logic in_data;
    logic w_hs;

    assign init_pulse = INIT_AXI_TXN & ~init_q;
    assign in_data    = (state_q == StData);
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            init_q      <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            txn_done_q  <= 1'b0;
            error_q     <= 1'b0;
            beat_q      <= '0;
            remaining_q <= '0;
        end else begin
            init_q <= INIT_AXI_TXN;
            unique case (state_q)
                StIdle, StDone: begin
                    if (init_pulse) begin
                        awaddr_q    <= BASE_ADDR & AlignMask;
                        remaining_q <= NUM_BURSTS;
                        error_q     <= 1'b0;
                        beat_q      <= '0;
                        if (NUM_BURSTS == '0) begin
                            state_q    <= StDone;
                            txn_done_q <= 1'b1;
                        end else begin
                            state_q    <= StAddr;
                            awvalid_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            txn_done_q <= 1'b0;
                        end
                    end
                end
                StAddr: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        if (M_AXI_WLAST) begin
                            beat_q   <= '0;
                            bready_q <= 1'b1;
                            state_q  <= StResp;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        remaining_q <= remaining_q - 1'b1;
                        awaddr_q    <= awaddr_q + AddrStep;
                        // SLVERR / DECERR latch until the next start; the transfer carries on.
                        if (M_AXI_BRESP[1]) begin
                            error_q <= 1'b1;
                        end
                        if (remaining_q == C_NUM_BURSTS_WIDTH'(1)) begin
                            state_q    <= StDone;
                            busy_q     <= 1'b0;
                            txn_done_q <= 1'b1;
                        end else begin
                            state_q   <= StAddr;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(BytesPerBeat));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA   = FIFO_DOUT;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = in_data & ~FIFO_EMPTY;
    assign M_AXI_WLAST   = in_data & (beat_q == LastBeat);
    assign FIFO_RD_EN    = w_hs;

    assign M_AXI_BREADY  = bready_q;
    assign BUSY          = busy_q;
    assign TXN_DONE      = txn_done_q;
    assign ERROR         = error_q;

    // BID and the low BRESP bit carry nothing this master acts on.
    logic unused_bresp;
    assign unused_bresp = ^{M_AXI_BID, M_AXI_BRESP[0]};

endmodule

// File: tb/tb_axi_fifoin_burst_writer.sv
// Randomised bench for axi_fifoin_burst_writer: FIFO + AXI slave model, memory scoreboard and
// a second 128-bit / 256-beat instance for alignment and AWSIZE.
module tb_axi_fifoin_burst_writer;

    localparam int unsigned BL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init;
    logic [31:0] base;
    logic [15:0] num;
    logic [31:0] fifo_dout;
    logic        fifo_empty, fifo_rd_en, busy, txn_done, error;
    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic        awlock, awvalid, awready;
    logic [3:0]  awcache, awqos;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [0:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_fifoin_burst_writer u_dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init),
        .BASE_ADDR(base), .NUM_BURSTS(num),
        .FIFO_DOUT(fifo_dout), .FIFO_EMPTY(fifo_empty), .FIFO_RD_EN(fifo_rd_en),
        .BUSY(busy), .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    // Wide instance: 128-bit data, 256-beat bursts, always-ready slave, never-empty FIFO.
    logic         w_init;
    logic [31:0]  w_base;
    logic [15:0]  w_num;
    logic [127:0] w_dout;
    logic         w_empty, w_rd_en, w_busy, w_done, w_error;
    logic [0:0]   w_awid, w_bid;
    logic [31:0]  w_awaddr;
    logic [7:0]   w_awlen;
    logic [2:0]   w_awsize, w_awprot;
    logic [1:0]   w_awburst, w_bresp;
    logic         w_awlock, w_awvalid, w_awready;
    logic [3:0]   w_awcache, w_awqos;
    logic [127:0] w_wdata;
    logic [15:0]  w_wstrb;
    logic         w_wlast, w_wvalid, w_wready, w_bvalid, w_bready;

    axi_fifoin_burst_writer #(
        .C_M_AXI_DATA_WIDTH(128), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_BURST_LEN(256),
        .C_M_AXI_ID_WIDTH(1), .C_NUM_BURSTS_WIDTH(16)
    ) u_dut_wide (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(w_init),
        .BASE_ADDR(w_base), .NUM_BURSTS(w_num),
        .FIFO_DOUT(w_dout), .FIFO_EMPTY(w_empty), .FIFO_RD_EN(w_rd_en),
        .BUSY(w_busy), .TXN_DONE(w_done), .ERROR(w_error),
        .M_AXI_AWID(w_awid), .M_AXI_AWADDR(w_awaddr), .M_AXI_AWLEN(w_awlen),
        .M_AXI_AWSIZE(w_awsize), .M_AXI_AWBURST(w_awburst), .M_AXI_AWLOCK(w_awlock),
        .M_AXI_AWCACHE(w_awcache), .M_AXI_AWPROT(w_awprot), .M_AXI_AWQOS(w_awqos),
        .M_AXI_AWVALID(w_awvalid), .M_AXI_AWREADY(w_awready),
        .M_AXI_WDATA(w_wdata), .M_AXI_WSTRB(w_wstrb), .M_AXI_WLAST(w_wlast),
        .M_AXI_WVALID(w_wvalid), .M_AXI_WREADY(w_wready),
        .M_AXI_BID(w_bid), .M_AXI_BRESP(w_bresp), .M_AXI_BVALID(w_bvalid),
        .M_AXI_BREADY(w_bready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state (narrow instance).
    logic [31:0] fifo_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] aw_addrs[$];
    logic [31:0] cur_addr;
    int aw_cnt, b_cnt, b_pending, beat, w_total, awvalid_cycles, err_burst;
    bit burst_open, rand_ready, err_check;

    always @(posedge clk) begin
        if (!rst_n) begin
            b_pending  = 0;
            beat       = 0;
            burst_open = 0;
            err_check  = 0;
        end else begin
            if (err_check) begin
                check_eq("error_after_slverr", error, 1);
                err_check = 0;
            end
            if (awvalid) awvalid_cycles++;
            if (fifo_empty) begin
                check_eq("wvalid_when_empty", wvalid, 0);
                check_eq("rd_en_when_empty", fifo_rd_en, 0);
            end
            if (awvalid && awready) begin
                check_eq("aw_one_outstanding", burst_open, 0);
                check_eq("awlen", awlen, BL - 1);
                check_eq("awsize", awsize, 2);
                check_eq("awburst", awburst, 1);
                check_eq("awcache", awcache, 3);
                check_eq("aw_zero_fields", {awprot, awlock, awqos, awid}, 0);
                aw_addrs.push_back(awaddr);
                cur_addr   = awaddr;
                burst_open = 1;
                beat       = 0;
                aw_cnt++;
            end
            if (wvalid && wready) begin
                check_eq("w_inside_burst", burst_open, 1);
                check_eq("rd_en_on_beat", fifo_rd_en, 1);
                check_eq("wstrb", wstrb, 4'hF);
                check_eq("wlast", wlast, beat == BL - 1);
                if (fifo_q.size() > 0) begin
                    check_eq("wdata", wdata, fifo_q[0]);
                    void'(fifo_q.pop_front());
                end
                mem[cur_addr + 32'(4 * beat)] = wdata;
                beat++;
                w_total++;
                if (beat == BL) b_pending++;
            end
            if (bvalid && bready) begin
                b_cnt++;
                b_pending--;
                burst_open = 0;
                if (bresp[1]) err_check = 1;
            end
        end
    end

    // Slave and FIFO drive on the falling edge.
    always @(negedge clk) begin
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
        awready    = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        wready     = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!rst_n || b_pending == 0) begin
            bvalid = 1'b0;
        end else if (!bvalid && (!rand_ready || $urandom_range(0, 1) == 1)) begin
            bvalid = 1'b1;
            bresp  = (b_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
        end
    end

    // Wide-instance monitor.
    logic [31:0] w_aw_addrs[$];
    int w_beats = 0;
    int w_lasts = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (w_awvalid && w_awready) begin
                w_aw_addrs.push_back(w_awaddr);
                check_eq("wide_awsize", w_awsize, 3'b100);
                check_eq("wide_awlen", w_awlen, 255);
            end
            if (w_wvalid && w_wready) begin
                if (w_wlast) begin
                    check_eq("wide_wlast_pos", w_beats % 256, 255);
                    w_lasts++;
                end
                w_beats++;
            end
        end
    end

    task automatic run_txn(input logic [31:0] b, input int n, input int prefill, input int errb,
                           input bit rdy, input bit retrig);
        int          total   = n * BL;
        logic [31:0] aligned = b & ~32'h3F;
        logic [31:0] dbase   = $urandom;
        logic [31:0] a;
        int          t;
        @(negedge clk);
        fifo_q.delete();
        mem.delete();
        aw_addrs.delete();
        aw_cnt = 0; b_cnt = 0; w_total = 0; awvalid_cycles = 0;
        err_burst  = errb;
        rand_ready = rdy;
        for (int i = 0; i < prefill; i++) fifo_q.push_back(dbase + 32'(i));
        base = b;
        num  = 16'(n);
        init = 1'b1;
        @(negedge clk);
        check_eq("start_awvalid", awvalid, n != 0);
        check_eq("start_busy", busy, n != 0);
        check_eq("start_error_clear", error, 0);
        if (n != 0) check_eq("start_done_clear", txn_done, 0);
        init = 1'b0;
        @(negedge clk);
        if (n == 0) begin
            check_eq("zero_done", txn_done, 1);
            check_eq("zero_busy", busy, 0);
        end
        if (retrig) begin
            repeat (8) @(negedge clk);
            check_eq("retrig_while_busy", busy, 1);
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
        end
        if (prefill < total) begin
            repeat (20) @(negedge clk);
            for (int i = prefill; i < total; i++) fifo_q.push_back(dbase + 32'(i));
        end
        t = 0;
        while (!txn_done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_within_bound", t < 5000, 1);
        repeat (2) @(negedge clk);
        check_eq("aw_count", aw_cnt, n);
        check_eq("b_count", b_cnt, n);
        if (n == 0) check_eq("zero_no_awvalid", awvalid_cycles, 0);
        check_eq("final_error", error, (errb >= 1 && errb <= n));
        check_eq("final_done", txn_done, 1);
        check_eq("final_busy", busy, 0);
        check_eq("fifo_drained", fifo_q.size(), 0);
        for (int i = 0; i < n; i++) begin
            a = aligned + 32'(i * 64);
            check_eq("awaddr", (i < aw_addrs.size()) ? aw_addrs[i] : 32'hFFFF_FFFF, a);
        end
        for (int i = 0; i < total; i++) begin
            a = aligned + 32'(4 * i);
            check_eq("mem_word", mem.exists(a) ? mem[a] : 32'hFFFF_FFFF, dbase + 32'(i));
        end
    endtask

    initial begin
        int n;
        int t;
        rst_n = 1'b0; init = 1'b0; base = '0; num = '0;
        bid = '0; bresp = 2'b00; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0; rand_ready = 0; err_burst = 0;
        w_init = 1'b0; w_base = '0; w_num = '0; w_dout = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        w_empty = 1'b0; w_awready = 1'b1; w_wready = 1'b1; w_bvalid = 1'b1;
        w_bresp = 2'b00; w_bid = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_wlast", wlast, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_status", {busy, txn_done, error}, 0);
        check_eq("rst_awaddr", awaddr, 0);
        rst_n = 1'b1;

        // Wide instance: BASE 0xFF0 aligns down to 0, second burst at 0x1000.
        @(negedge clk);
        w_base = 32'h0000_0FF0; w_num = 16'd2; w_init = 1'b1;
        @(negedge clk);
        w_init = 1'b0;
        t = 0;
        while (!w_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("wide_done_within_bound", t < 3000, 1);
        check_eq("wide_aw_count", w_aw_addrs.size(), 2);
        check_eq("wide_awaddr0", (w_aw_addrs.size() > 0) ? w_aw_addrs[0] : 32'hFFFF_FFFF, 0);
        check_eq("wide_awaddr1", (w_aw_addrs.size() > 1) ? w_aw_addrs[1] : 32'hFFFF_FFFF,
                 32'h1000);
        check_eq("wide_beats", w_beats, 512);
        check_eq("wide_lasts", w_lasts, 2);
        check_eq("wide_error", w_error, 0);

        run_txn(32'h1000_0000, 4, 64, 0, 0, 0);   // basic
        run_txn(32'h1000_0000, 0, 0, 0, 0, 0);    // zero bursts
        run_txn(32'h2000_0100, 1, 5, 0, 0, 0);    // FIFO starvation mid-burst
        run_txn(32'h3000_0000, 3, 48, 2, 0, 0);   // SLVERR on burst 2 of 3
        run_txn(32'h4000_0000, 4, 64, 0, 0, 1);   // INIT while busy is ignored
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 4);
            run_txn($urandom, n, n * BL, $urandom_range(0, n), 1, 0);
        end

        // Reset in the middle of a data phase.
        @(negedge clk);
        fifo_q.delete();
        rand_ready = 0;
        w_total = 0;
        for (int i = 0; i < 64; i++) fifo_q.push_back(32'(i));
        base = 32'h5000_0000; num = 16'd4; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        t = 0;
        while (w_total < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_data_reached", w_total >= 5, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_awvalid", awvalid, 0);
        check_eq("midrst_wvalid", wvalid, 0);
        check_eq("midrst_wlast", wlast, 0);
        check_eq("midrst_bready", bready, 0);
        check_eq("midrst_rd_en", fifo_rd_en, 0);
        check_eq("midrst_status", {busy, txn_done, error}, 0);
        check_eq("midrst_awaddr", awaddr, 0);
        repeat (2) @(negedge clk);
        fifo_q.delete();
        rst_n = 1'b1;
        run_txn(32'h6000_0040, 2, 32, 1, 1, 0);   // recovers after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
